issue_exec_stage: RTL and testbench
===================================

ISSUE_EXEC_STAGE -- requirements
Module: issue_exec_stage

Interface
REQ-001 SHALL have parameter NUM_ALU, default 2, number of ALU lanes (1..4); lane NUM_ALU is the memory lane.
REQ-002 SHALL have parameter NL = NUM_ALU+1, default 3, total lanes (derived, not overridden).
REQ-003 i_clk  in  1  sole clock, rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_issue_valid  in  [NL]  per-lane issue request.
REQ-006 i_issue_inst  in  rs_row_struct [NL]  issued reservation-station row per lane.
REQ-007 o_fu_ready  out  [NL]  lane can accept an issue this cycle.
REQ-008 o_complete_result  out  complete_stage_struct [NL]  per-lane result; .ready marks valid.
REQ-009 i_complete_ready  in  [NL]  completion stage consumes the lane result this cycle.
REQ-010 o_mem_req / o_mem_we / o_mem_addr / o_mem_wdata  out  1/1/word/word  memory request.
REQ-011 i_mem_gnt / i_mem_rvalid / i_mem_rdata  in  1/1/word  grant, read-data valid, read data.

Function
REQ-012 Issue on lane k SHALL fire when i_issue_valid[k] && o_fu_ready[k]; no X-propagation checks SHALL be used.
REQ-013 ALU lane SHALL compute via alu sub-module: operand0=src0, operand1=ALUSrc?immediate:src1, op=ALUOp.
REQ-014 ALU lane latency SHALL be exactly 1 cycle: result registered on the edge of the fire cycle.
REQ-015 ALU output register SHALL hold until i_complete_ready[k]; o_fu_ready[k] = !result.ready || i_complete_ready[k] (back-to-back issue at full rate).
REQ-016 Unsupported ALUOp (alu valid low) SHALL still complete, with FU_Result=0 and ready=1, so the ROB entry retires.
REQ-017 Completion fields SHALL be: ROBNumber, RegWrite, MemWrite from issued row; fu=k; FU_Result=result.
REQ-018 Memory lane FSM SHALL have states IDLE, REQ, WAIT, RESP; o_fu_ready[mem]=1 only in IDLE.
REQ-019 IDLE->REQ on fire; latch row, addr=src0+(ALUSrc?immediate:src1), wdata=src1, we=MemWrite.
REQ-020 REQ: o_mem_req=1 with stable addr/we/wdata until i_mem_gnt; on gnt: store->RESP, load->WAIT (or RESP if i_mem_rvalid same cycle).
REQ-021 WAIT->RESP on i_mem_rvalid, capturing i_mem_rdata.
REQ-022 RESP: result.ready=1 (load FU_Result=rdata, store FU_Result=addr); RESP->IDLE on i_complete_ready.
REQ-023 i_mem_rvalid outside WAIT/REQ SHALL be ignored.
REQ-024 Address arithmetic SHALL wrap modulo 2^32, no overflow flag.
REQ-025 When result.ready=0, all other completion fields SHALL be driven 0 (never X).

Reset
REQ-026 On i_rst_n low, immediately: all completion results 0, ALU o_fu_ready=1, memory FSM IDLE, o_mem_req=0, addr/wdata 0.
REQ-027 Reset mid-transaction SHALL abandon the memory access; a later i_mem_rvalid SHALL be ignored.

Configuration
REQ-028 Macro ISSUE_PERF_CNT_EN SHALL, when defined, add outputs o_perf_issue [NL] (32-bit saturating fires per lane) and o_perf_mem_stall (32-bit saturating cycles in REQ or WAIT), reset to 0.
REQ-029 Without ISSUE_PERF_CNT_EN, these ports and counters SHALL not exist; function otherwise identical.

Structure
REQ-030 word, rs_row_struct, complete_stage_struct and a new mem_fsm_e enum SHALL live in package Types.
REQ-031 Exactly one sub-module type, alu, instantiated NUM_ALU times via generate; memory address adder inline.

Verification
REQ-032 Lane0 ADD src0=5 src1=7 fire cycle t -> lane0 ready=1, FU_Result=12, fu=0 at t+1.
REQ-033 Lane1 result held with i_complete_ready=0 for 3 cycles -> o_fu_ready[1]=0, result stable; ready asserted -> o_fu_ready[1]=1 same cycle.
REQ-034 Load src0=0x100 imm=4 ALUSrc=1, gnt after 2 cycles, rvalid 3 cycles later rdata=0xDEADBEEF -> o_mem_addr=0x104, result FU_Result=0xDEADBEEF, fu=NUM_ALU.
REQ-035 Store src0=0xFFFFFFFC imm=8 -> o_mem_addr=0x4, o_mem_we=1, completes after gnt with no rvalid.
REQ-036 Reset asserted in WAIT, then spurious rvalid -> FSM IDLE, no completion, o_fu_ready[mem]=1.
REQ-037 With ISSUE_PERF_CNT_EN: 4 lane0 fires and 5 memory-wait cycles -> o_perf_issue[0]=4, o_perf_mem_stall=5.

Source files
------------

// File: rtl/issue_exec_stage_pkg.sv
// ============================================================================
// Module      : Types (package)
// Description : Shared types for the issue/execute stage: machine word,
//               reservation-station row, completion record, ALU opcodes and
//               the memory-lane FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package Types;

    typedef logic [31:0] word;

    localparam int ROB_W = 4;
    localparam int OP_W  = 4;
    localparam int FU_W  = 3;

    // ALU operation codes; anything above c_OP_SLT is unsupported
    localparam logic [OP_W-1:0] c_OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] c_OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] c_OP_AND = 4'd2;
    localparam logic [OP_W-1:0] c_OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] c_OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] c_OP_SLL = 4'd5;
    localparam logic [OP_W-1:0] c_OP_SRL = 4'd6;
    localparam logic [OP_W-1:0] c_OP_SLT = 4'd7;

    typedef struct packed {
        logic [ROB_W-1:0] ROBNumber;
        logic             RegWrite;
        logic             MemWrite;
        logic             ALUSrc;
        logic [OP_W-1:0]  ALUOp;
        word              src0;
        word              src1;
        word              immediate;
    } rs_row_struct;

    typedef struct packed {
        logic             ready;
        logic [ROB_W-1:0] ROBNumber;
        logic             RegWrite;
        logic             MemWrite;
        logic [FU_W-1:0]  fu;
        word              FU_Result;
    } complete_stage_struct;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_fsm_e;

    // Second operand selection shared by the ALU lanes and the address adder
    function automatic word sel_operand1(input rs_row_struct row);
        return row.ALUSrc ? row.immediate : row.src1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_exec_stage_if.sv
// ============================================================================
// Module      : issue_exec_stage_if
// Description : Issue, completion and memory bus bundle of the issue/execute
//               stage. slave = the stage, master = its environment.
//   i_issue_valid/i_issue_inst   : per-lane issue request and row
//   o_fu_ready                   : per-lane issue acceptance
//   o_complete_result            : per-lane completion record
//   i_complete_ready             : per-lane completion consume
//   o_mem_* / i_mem_*            : single outstanding memory request port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface issue_exec_stage_if #(
    parameter int NUM_ALU = 2
);
    import Types::*;

    localparam int NL = NUM_ALU + 1;

    logic [NL-1:0]        i_issue_valid;
    rs_row_struct         i_issue_inst [NL];
    logic [NL-1:0]        o_fu_ready;
    complete_stage_struct o_complete_result [NL];
    logic [NL-1:0]        i_complete_ready;

    logic                 o_mem_req;
    logic                 o_mem_we;
    word                  o_mem_addr;
    word                  o_mem_wdata;
    logic                 i_mem_gnt;
    logic                 i_mem_rvalid;
    word                  i_mem_rdata;

    modport slave (
        input  i_issue_valid, i_issue_inst, i_complete_ready,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_fu_ready, o_complete_result,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_issue_valid, i_issue_inst, i_complete_ready,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_fu_ready, o_complete_result,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/issue_exec_stage_alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational integer ALU. o_valid is low for unsupported
//               opcodes, in which case o_result is 0.
//   i_op, i_operand0, i_operand1 : opcode and operands
//   o_result, o_valid            : result and opcode-supported flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import Types::*;
(
    input  wire logic [OP_W-1:0] i_op,
    input  wire word             i_operand0,
    input  wire word             i_operand1,
    output word                  o_result,
    output logic                 o_valid
);

    always_comb begin
        o_result = '0;
        o_valid  = 1'b1;
        case (i_op)
            c_OP_ADD: o_result = i_operand0 + i_operand1;
            c_OP_SUB: o_result = i_operand0 - i_operand1;
            c_OP_AND: o_result = i_operand0 & i_operand1;
            c_OP_OR : o_result = i_operand0 | i_operand1;
            c_OP_XOR: o_result = i_operand0 ^ i_operand1;
            c_OP_SLL: o_result = i_operand0 << i_operand1[4:0];
            c_OP_SRL: o_result = i_operand0 >> i_operand1[4:0];
            c_OP_SLT: o_result = {31'd0, $signed(i_operand0) < $signed(i_operand1)};
            default : o_valid  = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/issue_exec_stage.sv
// ============================================================================
// Module      : issue_exec_stage
// Description : Issue/execute stage with NUM_ALU single-cycle ALU lanes and
//               one memory lane (lane NUM_ALU) driving a request/grant/rvalid
//               memory port. Each lane holds its result until consumed.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   bus (slave)      : issue, completion and memory signals
//   o_perf_issue     : saturating per-lane fire counters   (ISSUE_PERF_CNT_EN)
//   o_perf_mem_stall : saturating REQ/WAIT cycle counter   (ISSUE_PERF_CNT_EN)
// Optional feature macro: ISSUE_PERF_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_exec_stage
    import Types::*;
#(
    parameter  int NUM_ALU = 2,
    localparam int NL      = NUM_ALU + 1
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    issue_exec_stage_if.slave bus
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_issue [NL],
    output logic [31:0] o_perf_mem_stall
`endif
);

    localparam int c_MEM = NUM_ALU;

    logic [NL-1:0] w_fire;

    // ------------------------------------------------------------------
    // ALU lanes: result registered on the fire edge, held until consumed.
    // A lane accepts a new issue in the same cycle its held result drains.
    // ------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < NUM_ALU; k++) begin : g_alu
            word                  w_res;
            logic                 w_valid;
            logic                 w_ready;
            complete_stage_struct r_res;

            alu u_alu (
                .i_op       (bus.i_issue_inst[k].ALUOp),
                .i_operand0 (bus.i_issue_inst[k].src0),
                .i_operand1 (sel_operand1(bus.i_issue_inst[k])),
                .o_result   (w_res),
                .o_valid    (w_valid)
            );

            assign w_ready   = !r_res.ready || bus.i_complete_ready[k];
            assign w_fire[k] = bus.i_issue_valid[k] && w_ready;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_res <= '0;
                end else if (w_fire[k]) begin
                    r_res.ready     <= 1'b1;
                    r_res.ROBNumber <= bus.i_issue_inst[k].ROBNumber;
                    r_res.RegWrite  <= bus.i_issue_inst[k].RegWrite;
                    r_res.MemWrite  <= bus.i_issue_inst[k].MemWrite;
                    r_res.fu        <= FU_W'(k);
                    // Unsupported opcodes still complete so the ROB entry retires
                    r_res.FU_Result <= w_valid ? w_res : '0;
                end else if (bus.i_complete_ready[k]) begin
                    r_res <= '0;
                end
            end

            assign bus.o_fu_ready[k]        = w_ready;
            assign bus.o_complete_result[k] = r_res;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Memory lane FSM
    // ------------------------------------------------------------------
    mem_fsm_e             r_state;
    rs_row_struct         r_row;
    word                  r_addr;
    word                  r_wdata;
    word                  r_rdata;
    logic                 r_we;
    complete_stage_struct w_mem_res;

    assign w_fire[c_MEM] = bus.i_issue_valid[c_MEM] && (r_state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire[c_MEM]) begin
                        r_row   <= bus.i_issue_inst[c_MEM];
                        // Wraps modulo 2^32
                        r_addr  <= bus.i_issue_inst[c_MEM].src0
                                 + sel_operand1(bus.i_issue_inst[c_MEM]);
                        r_wdata <= bus.i_issue_inst[c_MEM].src1;
                        r_we    <= bus.i_issue_inst[c_MEM].MemWrite;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.i_mem_gnt) begin
                        if (r_we) begin
                            r_state <= RESP;
                        end else if (bus.i_mem_rvalid) begin
                            // Memory may return read data in the grant cycle
                            r_rdata <= bus.i_mem_rdata;
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        r_rdata <= bus.i_mem_rdata;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.i_complete_ready[c_MEM]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_mem_res = '0;
        if (r_state == RESP) begin
            w_mem_res.ready     = 1'b1;
            w_mem_res.ROBNumber = r_row.ROBNumber;
            w_mem_res.RegWrite  = r_row.RegWrite;
            w_mem_res.MemWrite  = r_row.MemWrite;
            w_mem_res.fu        = FU_W'(c_MEM);
            // Stores report their effective address as the result
            w_mem_res.FU_Result = r_we ? r_addr : r_rdata;
        end
    end

    assign bus.o_fu_ready[c_MEM]        = (r_state == IDLE);
    assign bus.o_complete_result[c_MEM] = w_mem_res;
    assign bus.o_mem_req                = (r_state == REQ);
    assign bus.o_mem_we                 = r_we;
    assign bus.o_mem_addr               = r_addr;
    assign bus.o_mem_wdata              = r_wdata;

`ifdef ISSUE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_issue [NL];
    logic [31:0] r_perf_mem_stall;

    generate
        for (k = 0; k < NL; k++) begin : g_perf
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_perf_issue[k] <= '0;
                end else if (w_fire[k] && (r_perf_issue[k] != '1)) begin
                    r_perf_issue[k] <= r_perf_issue[k] + 32'd1;
                end
            end
            assign o_perf_issue[k] = r_perf_issue[k];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_mem_stall <= '0;
        end else if (((r_state == REQ) || (r_state == WAIT)) && (r_perf_mem_stall != '1)) begin
            r_perf_mem_stall <= r_perf_mem_stall + 32'd1;
        end
    end

    assign o_perf_mem_stall = r_perf_mem_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_exec_stage.sv
// ============================================================================
// Module      : tb_issue_exec_stage
// Description : Directed self-checking bench for issue_exec_stage
//               (NUM_ALU = 2, memory lane = 2). Inputs change on the falling
//               edge; outputs are sampled on the falling edge or shortly
//               after an input change for same-cycle combinational paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_exec_stage;
    import Types::*;

    localparam int NUM_ALU = 2;
    localparam int NL      = NUM_ALU + 1;
    localparam int MEM     = NUM_ALU;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    issue_exec_stage_if #(.NUM_ALU(NUM_ALU)) bus ();

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_issue [NL];
    logic [31:0] perf_mem_stall;
`endif

    issue_exec_stage #(.NUM_ALU(NUM_ALU)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .o_perf_issue     (perf_issue),
        .o_perf_mem_stall (perf_mem_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rs_row_struct mk_row(input logic [3:0] rob, input logic rw, input logic mw,
                                            input logic asrc, input logic [3:0] op,
                                            input word s0, input word s1, input word imm);
        rs_row_struct r;
        r.ROBNumber = rob; r.RegWrite = rw; r.MemWrite = mw; r.ALUSrc = asrc;
        r.ALUOp = op; r.src0 = s0; r.src1 = s1; r.immediate = imm;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_issue_valid    = '0;
        bus.i_complete_ready = '0;
        bus.i_mem_gnt        = 1'b0;
        bus.i_mem_rvalid     = 1'b0;
        bus.i_mem_rdata      = '0;
        for (int i = 0; i < NL; i++) bus.i_issue_inst[i] = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (bus.o_complete_result[i] !== '0) begin errors++; $display("FAIL reset_result[%0d] got %h exp 0", i, bus.o_complete_result[i]); end
        end
        checks++; if (bus.o_fu_ready !== 3'b111) begin errors++; $display("FAIL reset_fu_ready got %b exp 111", bus.o_fu_ready); end
        checks++; if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.o_mem_req); end
        checks++; if (bus.o_mem_addr !== 32'h0 || bus.o_mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got %h/%h exp 0/0", bus.o_mem_addr, bus.o_mem_wdata); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_add();
        bus.i_issue_inst[0]  = mk_row(4'd3, 1'b1, 1'b0, 1'b0, c_OP_ADD, 32'd5, 32'd7, 32'd100);
        bus.i_issue_valid[0] = 1'b1;
        #1;
        checks++; if (bus.o_fu_ready[0] !== 1'b1) begin errors++; $display("FAIL add_fu_ready_idle got %b exp 1", bus.o_fu_ready[0]); end
        tick();
        bus.i_issue_valid[0] = 1'b0;
        checks++; if (bus.o_complete_result[0].ready !== 1'b1 || bus.o_complete_result[0].FU_Result !== 32'd12)
            begin errors++; $display("FAIL add_result got rdy=%b res=%0d exp rdy=1 res=12", bus.o_complete_result[0].ready, bus.o_complete_result[0].FU_Result); end
        checks++; if (bus.o_complete_result[0].fu !== 3'd0 || bus.o_complete_result[0].ROBNumber !== 4'd3 || bus.o_complete_result[0].RegWrite !== 1'b1)
            begin errors++; $display("FAIL add_fields got fu=%0d rob=%0d rw=%b exp fu=0 rob=3 rw=1", bus.o_complete_result[0].fu, bus.o_complete_result[0].ROBNumber, bus.o_complete_result[0].RegWrite); end
        checks++; if (bus.o_fu_ready[0] !== 1'b0) begin errors++; $display("FAIL add_fu_ready_busy got %b exp 0", bus.o_fu_ready[0]); end
        bus.i_complete_ready[0] = 1'b1;
        tick();
        bus.i_complete_ready[0] = 1'b0;
        checks++; if (bus.o_complete_result[0] !== '0) begin errors++; $display("FAIL add_drained got %h exp 0", bus.o_complete_result[0]); end
    endtask

    task automatic test_alu_hold();
        // ALUSrc selects the immediate: 20 - 6 = 14 (src1 = 99 must be ignored)
        bus.i_issue_inst[1]  = mk_row(4'd6, 1'b1, 1'b0, 1'b1, c_OP_SUB, 32'd20, 32'd99, 32'd6);
        bus.i_issue_valid[1] = 1'b1;
        tick();
        bus.i_issue_valid[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.o_fu_ready[1] !== 1'b0 || bus.o_complete_result[1].FU_Result !== 32'd14 || bus.o_complete_result[1].ready !== 1'b1)
                begin errors++; $display("FAIL hold_c%0d got frdy=%b rdy=%b res=%0d exp 0/1/14", c, bus.o_fu_ready[1], bus.o_complete_result[1].ready, bus.o_complete_result[1].FU_Result); end
            tick();
        end
        bus.i_complete_ready[1] = 1'b1;
        #1;
        checks++; if (bus.o_fu_ready[1] !== 1'b1) begin errors++; $display("FAIL hold_release got %b exp 1", bus.o_fu_ready[1]); end
        tick();
        bus.i_complete_ready[1] = 1'b0;
    endtask

    task automatic test_unsupported();
        bus.i_issue_inst[1]  = mk_row(4'd9, 1'b1, 1'b0, 1'b0, 4'hF, 32'd1, 32'd2, 32'd0);
        bus.i_issue_valid[1] = 1'b1;
        tick();
        bus.i_issue_valid[1] = 1'b0;
        checks++; if (bus.o_complete_result[1].ready !== 1'b1 || bus.o_complete_result[1].FU_Result !== 32'd0 ||
                      bus.o_complete_result[1].fu !== 3'd1 || bus.o_complete_result[1].ROBNumber !== 4'd9)
            begin errors++; $display("FAIL unsupported got %h exp rdy=1 res=0 fu=1 rob=9", bus.o_complete_result[1]); end
        bus.i_complete_ready[1] = 1'b1;
        tick();
        bus.i_complete_ready[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        rs_row_struct rows [4];
        word          exp  [4];
        rows[0] = mk_row(4'd1, 1'b1, 1'b0, 1'b0, c_OP_AND, 32'hF0F0, 32'hFF00, 32'd0); exp[0] = 32'hF000;
        rows[1] = mk_row(4'd2, 1'b1, 1'b0, 1'b0, c_OP_OR,  32'h0F,   32'hF0,   32'd0); exp[1] = 32'hFF;
        rows[2] = mk_row(4'd3, 1'b1, 1'b0, 1'b1, c_OP_XOR, 32'hFF,   32'd0,    32'h0F); exp[2] = 32'hF0;
        rows[3] = mk_row(4'd4, 1'b1, 1'b0, 1'b0, c_OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd0); exp[3] = 32'd1;
        bus.i_complete_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_issue_inst[0]  = rows[i];
            bus.i_issue_valid[0] = 1'b1;
            #1;
            checks++; if (bus.o_fu_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, bus.o_fu_ready[0]); end
            tick();
            checks++; if (bus.o_complete_result[0].FU_Result !== exp[i] || bus.o_complete_result[0].ROBNumber !== rows[i].ROBNumber)
                begin errors++; $display("FAIL b2b_result[%0d] got %h rob %0d exp %h rob %0d", i, bus.o_complete_result[0].FU_Result, bus.o_complete_result[0].ROBNumber, exp[i], rows[i].ROBNumber); end
        end
        bus.i_issue_valid[0] = 1'b0;
        tick();
        bus.i_complete_ready[0] = 1'b0;
    endtask

    task automatic test_load();
        bus.i_issue_inst[MEM]  = mk_row(4'd5, 1'b1, 1'b0, 1'b1, c_OP_ADD, 32'h100, 32'h55, 32'd4);
        bus.i_issue_valid[MEM] = 1'b1;
        #1;
        checks++; if (bus.o_fu_ready[MEM] !== 1'b1) begin errors++; $display("FAIL load_fu_ready_idle got %b exp 1", bus.o_fu_ready[MEM]); end
        tick();
        bus.i_issue_valid[MEM] = 1'b0;
        checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h104 || bus.o_mem_we !== 1'b0 || bus.o_fu_ready[MEM] !== 1'b0)
            begin errors++; $display("FAIL load_req got req=%b addr=%h we=%b frdy=%b exp 1/104/0/0", bus.o_mem_req, bus.o_mem_addr, bus.o_mem_we, bus.o_fu_ready[MEM]); end
        tick();
        checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h104) begin errors++; $display("FAIL load_req_stable got req=%b addr=%h exp 1/104", bus.o_mem_req, bus.o_mem_addr); end
        bus.i_mem_gnt = 1'b1;
        tick();
        bus.i_mem_gnt = 1'b0;
        checks++; if (bus.o_mem_req !== 1'b0 || bus.o_complete_result[MEM].ready !== 1'b0)
            begin errors++; $display("FAIL load_wait got req=%b rdy=%b exp 0/0", bus.o_mem_req, bus.o_complete_result[MEM].ready); end
        tick();
        tick();
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hDEADBEEF;
        tick();
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'h0;
        checks++; if (bus.o_complete_result[MEM].ready !== 1'b1 || bus.o_complete_result[MEM].FU_Result !== 32'hDEADBEEF ||
                      bus.o_complete_result[MEM].fu !== 3'd2 || bus.o_complete_result[MEM].ROBNumber !== 4'd5)
            begin errors++; $display("FAIL load_result got %h exp rdy=1 res=deadbeef fu=2 rob=5", bus.o_complete_result[MEM]); end
        bus.i_complete_ready[MEM] = 1'b1;
        #1;
        checks++; if (bus.o_fu_ready[MEM] !== 1'b0) begin errors++; $display("FAIL load_resp_fu_ready got %b exp 0", bus.o_fu_ready[MEM]); end
        tick();
        bus.i_complete_ready[MEM] = 1'b0;
        checks++; if (bus.o_complete_result[MEM] !== '0 || bus.o_fu_ready[MEM] !== 1'b1)
            begin errors++; $display("FAIL load_done got %h frdy=%b exp 0/1", bus.o_complete_result[MEM], bus.o_fu_ready[MEM]); end
        // Stray read data while idle must not produce a completion
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h12345678;
        tick();
        bus.i_mem_rvalid = 1'b0;
        checks++; if (bus.o_complete_result[MEM].ready !== 1'b0 || bus.o_fu_ready[MEM] !== 1'b1)
            begin errors++; $display("FAIL idle_rvalid got rdy=%b frdy=%b exp 0/1", bus.o_complete_result[MEM].ready, bus.o_fu_ready[MEM]); end
    endtask

    task automatic test_store();
        bus.i_issue_inst[MEM]  = mk_row(4'd7, 1'b0, 1'b1, 1'b1, c_OP_ADD, 32'hFFFFFFFC, 32'hCAFE, 32'd8);
        bus.i_issue_valid[MEM] = 1'b1;
        tick();
        bus.i_issue_valid[MEM] = 1'b0;
        checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h4 || bus.o_mem_we !== 1'b1 || bus.o_mem_wdata !== 32'hCAFE)
            begin errors++; $display("FAIL store_req got req=%b addr=%h we=%b wd=%h exp 1/4/1/cafe", bus.o_mem_req, bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wdata); end
        bus.i_mem_gnt = 1'b1;
        tick();
        bus.i_mem_gnt = 1'b0;
        checks++; if (bus.o_complete_result[MEM].ready !== 1'b1 || bus.o_complete_result[MEM].FU_Result !== 32'h4 ||
                      bus.o_complete_result[MEM].MemWrite !== 1'b1 || bus.o_complete_result[MEM].ROBNumber !== 4'd7 || bus.o_mem_req !== 1'b0)
            begin errors++; $display("FAIL store_result got %h req=%b exp rdy=1 res=4 mw=1 rob=7 req=0", bus.o_complete_result[MEM], bus.o_mem_req); end
        bus.i_complete_ready[MEM] = 1'b1;
        tick();
        bus.i_complete_ready[MEM] = 1'b0;
        checks++; if (bus.o_complete_result[MEM].ready !== 1'b0) begin errors++; $display("FAIL store_done got %b exp 0", bus.o_complete_result[MEM].ready); end
    endtask

    task automatic test_reset_in_wait();
        bus.i_issue_inst[MEM]  = mk_row(4'd2, 1'b1, 1'b0, 1'b0, c_OP_ADD, 32'h200, 32'h0, 32'h0);
        bus.i_issue_valid[MEM] = 1'b1;
        tick();
        bus.i_issue_valid[MEM] = 1'b0;
        bus.i_mem_gnt          = 1'b1;
        bus.i_issue_inst[0]    = mk_row(4'd1, 1'b1, 1'b0, 1'b0, c_OP_ADD, 32'd1, 32'd1, 32'd0);
        bus.i_issue_valid[0]   = 1'b1;
        tick();
        bus.i_mem_gnt        = 1'b0;
        bus.i_issue_valid[0] = 1'b0;
        checks++; if (bus.o_complete_result[0].ready !== 1'b1 || bus.o_mem_req !== 1'b0)
            begin errors++; $display("FAIL rst_pre got rdy0=%b req=%b exp 1/0", bus.o_complete_result[0].ready, bus.o_mem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_fu_ready !== 3'b111 || bus.o_mem_req !== 1'b0 || bus.o_mem_addr !== 32'h0 || bus.o_mem_wdata !== 32'h0)
            begin errors++; $display("FAIL rst_async got frdy=%b req=%b addr=%h wd=%h exp 111/0/0/0", bus.o_fu_ready, bus.o_mem_req, bus.o_mem_addr, bus.o_mem_wdata); end
        checks++; if (bus.o_complete_result[0] !== '0 || bus.o_complete_result[MEM] !== '0)
            begin errors++; $display("FAIL rst_results got %h/%h exp 0/0", bus.o_complete_result[0], bus.o_complete_result[MEM]); end
        tick();
        rst_n            = 1'b1;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hBAD;
        tick();
        bus.i_mem_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (bus.o_complete_result[MEM].ready !== 1'b0 || bus.o_fu_ready[MEM] !== 1'b1 || bus.o_mem_req !== 1'b0)
                begin errors++; $display("FAIL rst_spurious_c%0d got rdy=%b frdy=%b req=%b exp 0/1/0", c, bus.o_complete_result[MEM].ready, bus.o_fu_ready[MEM], bus.o_mem_req); end
            tick();
        end
    endtask

`ifdef ISSUE_PERF_CNT_EN
    task automatic test_perf();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++; if (perf_issue[0] !== 32'd0 || perf_mem_stall !== 32'd0)
            begin errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_issue[0], perf_mem_stall); end
        tick();
        rst_n = 1'b1;
        bus.i_complete_ready[0] = 1'b1;
        bus.i_issue_inst[0]     = mk_row(4'd1, 1'b1, 1'b0, 1'b0, c_OP_ADD, 32'd1, 32'd2, 32'd0);
        bus.i_issue_valid[0]    = 1'b1;
        repeat (4) tick();
        bus.i_issue_valid[0]    = 1'b0;
        bus.i_issue_inst[MEM]   = mk_row(4'd3, 1'b1, 1'b0, 1'b0, c_OP_ADD, 32'h10, 32'h0, 32'h0);
        bus.i_issue_valid[MEM]  = 1'b1;
        tick();
        bus.i_issue_valid[MEM]  = 1'b0;
        tick();
        bus.i_mem_gnt = 1'b1;
        tick();
        bus.i_mem_gnt = 1'b0;
        tick();
        tick();
        bus.i_mem_rvalid = 1'b1;
        tick();
        bus.i_mem_rvalid = 1'b0;
        bus.i_complete_ready[MEM] = 1'b1;
        tick();
        bus.i_complete_ready = '0;
        checks++; if (perf_issue[0] !== 32'd4) begin errors++; $display("FAIL perf_issue0 got %0d exp 4", perf_issue[0]); end
        checks++; if (perf_mem_stall !== 32'd5) begin errors++; $display("FAIL perf_mem_stall got %0d exp 5", perf_mem_stall); end
        checks++; if (perf_issue[MEM] !== 32'd1 || perf_issue[1] !== 32'd0)
            begin errors++; $display("FAIL perf_issue_other got %0d/%0d exp 1/0", perf_issue[MEM], perf_issue[1]); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_add();
        test_alu_hold();
        test_unsupported();
        test_back_to_back();
        test_load();
        test_store();
        test_reset_in_wait();
`ifdef ISSUE_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
